// File: rtl/count_seq_checker.sv
// count_seq_checker: lock onto a 3-bit up-count and flag errors and wraps once locked.
// Optional macro CHK_TERM_EN: when defined, the D4 terminal flag is part of the correctness check.
`default_nettype none

module count_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       EN,
  input  logic       CLR,
  output logic       LOCK,
  output logic       ERR,
  output logic       WRAP,
  output logic [7:0] ERRCNT
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_MAX_C = 4'(MISS_MAX);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic [2:0]  exp_q, exp_d;
  logic [2:0]  prev_q, prev_d;
  logic [3:0]  run_q, run_d;
  logic [3:0]  miss_q, miss_d;
  logic        err_q, err_d;
  logic        wrap_q, wrap_d;
  logic [7:0]  errcnt_q, errcnt_d;
  logic [2:0]  v;
  logic        correct;
  logic        err_inc;

  assign v = {D1, D2, D3};

`ifdef CHK_TERM_EN
  assign correct = (v == exp_q) && (D4 == (v == 3'd0));
`else
  logic unused_d4;
  assign unused_d4 = D4;
  assign correct   = (v == exp_q);
`endif

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    exp_d   = exp_q;
    prev_d  = prev_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;

    if (EN) begin
      prev_d = v;
      case (state_q)
        ST_HUNT: begin
          // Always resynchronise to the observed value; the first sample is never judged.
          exp_d   = v + 3'd1;
          first_d = 1'b0;
          if (first_q || !correct) begin
            run_d = 4'd1;
          end else begin
            run_d = run_q + 4'd1;
          end
          if (run_d >= LOCK_CNT_C) begin
            state_d = ST_LOCKED;
            miss_d  = 4'd0;
          end
        end
        ST_LOCKED: begin
          exp_d = exp_q + 3'd1;
          if (correct) begin
            miss_d = 4'd0;
            wrap_d = (exp_q == 3'd0) && (prev_q == 3'd7);
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_q + 4'd1;
            if (miss_d >= MISS_MAX_C) begin
              state_d = ST_HUNT;
              first_d = 1'b1;
              run_d   = 4'd0;
              miss_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          first_d = 1'b1;
        end
      endcase
    end

    // A clear coinciding with an error leaves the count at one.
    if (CLR) begin
      errcnt_d = {7'd0, err_inc};
    end else if (err_inc && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= ST_HUNT;
      first_q  <= 1'b1;
      exp_q    <= 3'd0;
      prev_q   <= 3'd0;
      run_q    <= 4'd0;
      miss_q   <= 4'd0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      exp_q    <= exp_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign LOCK   = (state_q == ST_LOCKED);
  assign ERR    = err_q;
  assign WRAP   = wrap_q;
  assign ERRCNT = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed samples with hand-computed expected outputs.
`default_nettype none

module tb_count_seq_checker;

  logic       CLK = 1'b0;
  logic       RSTN, D1, D2, D3, D4, EN, CLR;
  logic       LOCK, ERR, WRAP;
  logic [7:0] ERRCNT;

  always #5 CLK = ~CLK;

  count_seq_checker #(.LOCK_CNT(4), .MISS_MAX(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .EN(EN), .CLR(CLR), .LOCK(LOCK), .ERR(ERR), .WRAP(WRAP), .ERRCNT(ERRCNT)
  );

  typedef struct {
    string       nm;
    logic [10:0] want;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [10:0] act;
  int          checks   = 0;
  int          failures = 0;

  // Monitor: one expected entry per sampled edge, compared half a cycle later.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {LOCK, ERR, WRAP, ERRCNT};
      checks++;
      if (act !== cur.want) begin
        failures++;
        $display("FAIL %s: got lock=%0b err=%0b wrap=%0b errcnt=%0d, want lock=%0b err=%0b wrap=%0b errcnt=%0d",
                 cur.nm, act[10], act[9], act[8], act[7:0],
                 cur.want[10], cur.want[9], cur.want[8], cur.want[7:0]);
      end
    end
  end

  task automatic step(input string nm, input bit rn, input bit en, input bit clr,
                      input logic [2:0] v, input bit d4,
                      input bit l, input bit e, input bit w, input int c);
    exp_t t;
    @(negedge CLK);
    RSTN = rn; EN = en; CLR = clr;
    {D1, D2, D3} = v; D4 = d4;
    @(posedge CLK);
    t.nm   = nm;
    t.want = {l, e, w, 8'(c)};
    sb.push_back(t);
  endtask

  // Normal enabled sample with a consistent terminal flag.
  task automatic smp(input string nm, input logic [2:0] v,
                     input bit l, input bit e, input bit w, input int c);
    step(nm, 1'b1, 1'b1, 1'b0, v, (v == 3'd0), l, e, w, c);
  endtask

  int         cnt_m;
  logic [2:0] e_m;

  initial begin
    RSTN = 1'b0; EN = 1'b0; CLR = 1'b0; {D1, D2, D3, D4} = 4'b0;

    step("reset0", 0, 1, 0, 3'd5, 0, 0, 0, 0, 0);
    step("reset1", 0, 1, 1, 3'd2, 0, 0, 0, 0, 0);

    // Acquire lock on 0,1,2,3.
    smp("hunt0", 3'd0, 0, 0, 0, 0);
    smp("hunt1", 3'd1, 0, 0, 0, 0);
    smp("hunt2", 3'd2, 0, 0, 0, 0);
    smp("lock3", 3'd3, 1, 0, 0, 0);

    // Wrap 7->0 while locked.
    smp("lk4", 3'd4, 1, 0, 0, 0);
    smp("lk5", 3'd5, 1, 0, 0, 0);
    smp("lk6", 3'd6, 1, 0, 0, 0);
    smp("lk7", 3'd7, 1, 0, 0, 0);
    smp("wrap0", 3'd0, 1, 0, 1, 0);
    step("en_hold", 1, 0, 0, 3'd5, 0, 1, 0, 0, 0);
    smp("lk1", 3'd1, 1, 0, 0, 0);
    smp("lk2", 3'd2, 1, 0, 0, 0);
    smp("lk3b", 3'd3, 1, 0, 0, 0);
    smp("lk4b", 3'd4, 1, 0, 0, 0);

    // EXP=5: one miss, recover, then two misses drop the lock.
    smp("miss3", 3'd3, 1, 1, 0, 1);
    smp("ok6", 3'd6, 1, 0, 0, 1);
    smp("miss1", 3'd1, 1, 1, 0, 2);
    smp("unlock2", 3'd2, 0, 1, 0, 3);

    // Relock starting from a first sample of 5.
    smp("rh5", 3'd5, 0, 0, 0, 3);
    smp("rh6", 3'd6, 0, 0, 0, 3);
    smp("rh7", 3'd7, 0, 0, 0, 3);
    smp("rlock0", 3'd0, 1, 0, 0, 3);
    for (int i = 1; i < 8; i++) smp("run", 3'(i), 1, 0, 0, 3);

    // Zero presented with D4=0.
`ifdef CHK_TERM_EN
    step("term_bad", 1, 1, 0, 3'd0, 0, 1, 1, 0, 4);
    cnt_m = 4;
`else
    step("term_ign", 1, 1, 0, 3'd0, 0, 1, 0, 1, 3);
    cnt_m = 3;
`endif
    smp("post1", 3'd1, 1, 0, 0, cnt_m);

    // Alternate wrong/right samples to reach ERRCNT=7 without losing lock.
    e_m = 3'd2;
    while (cnt_m < 7) begin
      cnt_m++;
      smp("alt_bad", e_m + 3'd4, 1, 1, 0, cnt_m);
      e_m = e_m + 3'd1;
      smp("alt_ok", e_m, 1, 0, 0, cnt_m);
      e_m = e_m + 3'd1;
    end

    // Reset mid-lock beats EN and CLR; relock needs four fresh samples.
    step("rst_lock", 0, 1, 1, 3'd3, 0, 0, 0, 0, 0);
    smp("rr0", 3'd0, 0, 0, 0, 0);
    smp("rr1", 3'd1, 0, 0, 0, 0);
    smp("rr2", 3'd2, 0, 0, 0, 0);
    smp("rr3", 3'd3, 1, 0, 0, 0);

    // 300 errors across repeated relocks saturate ERRCNT.
    step("rst_sat", 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
    cnt_m = 0;
    for (int k = 0; k < 150; k++) begin
      smp("s0", 3'd0, 0, 0, 0, cnt_m);
      smp("s1", 3'd1, 0, 0, 0, cnt_m);
      smp("s2", 3'd2, 0, 0, 0, cnt_m);
      smp("s3", 3'd3, 1, 0, 0, cnt_m);
      cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
      smp("sbad1", 3'd7, 1, 1, 0, cnt_m);
      cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
      smp("sbad2", 3'd7, 0, 1, 0, cnt_m);
    end

    step("clr_only", 1, 0, 1, 3'd4, 0, 0, 0, 0, 0);
    smp("c0", 3'd0, 0, 0, 0, 0);
    smp("c1", 3'd1, 0, 0, 0, 0);
    smp("c2", 3'd2, 0, 0, 0, 0);
    smp("c3", 3'd3, 1, 0, 0, 0);
    step("clr_err", 1, 1, 1, 3'd7, 0, 1, 1, 0, 1);
    step("idle", 1, 0, 0, 3'd0, 0, 1, 0, 0, 1);

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, meaning consecutive correct samples needed to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter MISS_MAX, default 2, meaning consecutive mismatches in LOCKED that force a return to HUNT (range 1..15).
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports D1,D2,D3  input  1 each  observed 3-bit up-count from the counter generator; D1 MSB, D3 LSB.
REQ-006 SHALL have port D4  input  1  observed terminal flag; high in the same cycle the count reads 0 after 7.
REQ-007 SHALL have port EN  input  1  sample enable; a sample is taken only on edges where EN=1.
REQ-008 SHALL have port CLR  input  1  clears ERRCNT.
REQ-009 SHALL have port LOCK  output  1  high while the FSM is in LOCKED.
REQ-010 SHALL have port ERR  output  1  one-cycle pulse per mismatching sample while LOCKED.
REQ-011 SHALL have port WRAP  output  1  one-cycle pulse per correct 7->0 transition while LOCKED.
REQ-012 SHALL have port ERRCNT  output  8  saturating count of ERR pulses.

Function
REQ-013 SHALL compute the observed value V={D1,D2,D3} and hold a 3-bit expected register EXP.
REQ-014 SHALL define a sample as correct when V==EXP and, with CHK_TERM_EN, D4==(V==0).
REQ-015 SHALL implement FSM states HUNT and LOCKED.
REQ-016 In HUNT, the first sample after reset or re-entry SHALL load EXP=V+1 (mod 8) without judging correctness and set the good-run counter to 1.
REQ-017 In HUNT, later samples SHALL follow these rules:
- correct: increment the good run and set EXP=V+1.
- incorrect: set the good run to 1 and set EXP=V+1 (resynchronise).
REQ-018 HUNT->LOCKED SHALL occur on the sample at which the good run reaches LOCK_CNT; LOCK SHALL rise on that edge.
REQ-019 In LOCKED, EXP SHALL advance to EXP+1 (mod 8) on every sample, correct or not (flywheel).
REQ-020 In LOCKED, a correct sample SHALL zero the miss counter.
REQ-021 In LOCKED, an incorrect sample SHALL pulse ERR, increment ERRCNT and increment the miss counter.
REQ-022 LOCKED->HUNT SHALL occur on the sample at which the miss counter reaches MISS_MAX; ERR SHALL still pulse for that sample, LOCK SHALL fall on the same edge, and the next sample is treated as a first sample.
REQ-023 WRAP SHALL pulse for a correct LOCKED sample with EXP==0 and the previous sample==7.
REQ-024 ERR and WRAP SHALL be registered and appear on the edge that samples the offending or wrapping value (1-cycle latency from input change); they SHALL never be high simultaneously.
REQ-025 ERRCNT SHALL saturate at 255 and SHALL NOT wrap.
REQ-026 CLR=1 SHALL set ERRCNT to 0; if CLR coincides with an error, ERRCNT SHALL become 1.
REQ-027 EN=0 SHALL hold all state and counters and force ERR=WRAP=0; CLR SHALL still act.

Reset
REQ-028 RSTN=0 at a rising CLK edge SHALL set state=HUNT, EXP=0, all run and miss counters=0, LOCK=0, ERR=0, WRAP=0 and ERRCNT=0, and SHALL mark the next sample as the first sample.
REQ-029 Reset SHALL take priority over EN and CLR, including mid-LOCKED.

Configuration
REQ-030 With macro CHK_TERM_EN defined, D4 SHALL take part in correctness per REQ-014.
REQ-031 Without CHK_TERM_EN, D4 SHALL be ignored and correctness SHALL be V==EXP only.

Verification
REQ-032 Reset, EN=1, feed 0,1,2,3 -> LOCK rises on the 4th sample edge; ERRCNT=0.
REQ-033 Locked, feed 4,5,6,7,0 with D4=1 at 0 -> exactly one WRAP pulse at the 0 sample; ERR never high.
REQ-034 Locked at EXP=5, feed 3 then 6 -> one ERR, ERRCNT=1, LOCK stays 1; then feed 1,2 -> two ERR pulses, ERRCNT=3, LOCK falls at the second of these.
REQ-035 CHK_TERM_EN defined, locked, feed 0 with D4=0 -> ERR pulse; undefined -> no ERR.
REQ-036 Force 300 errors with repeated relock -> ERRCNT=255; CLR alone -> 0; CLR with error -> 1.
REQ-037 RSTN=0 for one edge while LOCKED with ERRCNT=7 -> all outputs 0 next cycle; relock requires 4 new samples.
